tri_buffer: RTL and testbench
=============================

TRI_BUFFER -- requirements
Module: tri_buffer

Interface
REQ-001 SHALL have parameter W, default 32, bit width of one coordinate word.
REQ-002 SHALL have parameter NC, default 4, coordinates per vertex (x,y,z,w).
REQ-003 SHALL have parameter NV, default 3, vertices per triangle.
REQ-004 SHALL have parameter DEPTH, default 16, entry count; power of two, >=2.
REQ-005 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold.
REQ-006 SHALL have parameter HOLD_OBJ, default 0, object-gated output mode when 1.
REQ-007 SHALL have ports, one per line:
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- flush_in  input  1  synchronous discard of all entries
- s_valid  input  1  upstream triangle valid
- s_ready  output  1  buffer can accept
- s_tri  input  NV*NC*W  packed triangle; vertex v, coordinate c at bits [(v*NC+c)*W +: W]
- s_last  input  1  final triangle of object (obj_done)
- m_valid  output  1  triangle available
- m_ready  input  1  downstream accepts
- m_tri  output  NV*NC*W  head triangle, same packing as s_tri
- m_last  output  1  head entry's s_last tag
- count_out  output  $clog2(DEPTH)+1  occupancy
- almost_full_out  output  1  count_out >= AF_LEVEL

Function
REQ-008 SHALL push when s_valid && s_ready at a rising edge, storing s_tri and s_last together.
REQ-009 SHALL pop when m_valid && m_ready at a rising edge.
REQ-010 SHALL drive s_ready = (count_out < DEPTH); no push while full, even with a same-cycle pop.
REQ-011 SHALL make a pushed entry visible on m_* no earlier than the cycle after the push edge; no combinational s_* to m_* path.
REQ-012 SHALL support a push and a pop in the same cycle when 0 < count < DEPTH, leaving count unchanged.
REQ-013 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-014 SHALL hold m_tri and m_last stable while m_valid && !m_ready.
REQ-015 SHALL maintain obj_cnt, the number of stored entries with last=1: +1 on push with s_last, -1 on pop with m_last, unchanged when both occur.
REQ-016 With HOLD_OBJ=0, SHALL drive m_valid = (count_out != 0).
REQ-017 With HOLD_OBJ=1, SHALL drive m_valid = (count_out != 0) && (obj_cnt != 0 || count_out == DEPTH).
- The full-buffer release prevents deadlock on objects larger than DEPTH.
REQ-018 SHALL give flush_in priority over push and pop: count, obj_cnt and pointers cleared at the edge; push or pop presented in that cycle is dropped.
REQ-019 SHALL update almost_full_out and count_out registered, consistent with the post-edge state.

Reset
REQ-020 While rst_in=0, SHALL force m_valid=0, m_last=0, s_ready=0, count_out=0, almost_full_out=0, with pointers and obj_cnt cleared immediately, without a clock.
REQ-021 After rst_in rises, SHALL assert s_ready=1 from the first rising edge.
- Storage contents are not reset; m_tri is don't-care while m_valid=0.
REQ-022 Reset asserted mid-transfer SHALL discard all entries; no partial entry survives.

Configuration
REQ-023 With TRI_BUFFER_HWM_EN defined:
- SHALL add output hwm_out, $clog2(DEPTH)+1 bits, the maximum count_out reached since reset or flush.
- hwm_out SHALL be cleared by rst_in and flush_in.
REQ-024 Without TRI_BUFFER_HWM_EN, port hwm_out and its logic SHALL be absent.

Verification
REQ-025 SHALL cover the following directed scenarios:
- Fill: DEPTH=16, m_ready=0, 16 pushes -> s_ready=0 after the 16th; almost_full_out=1 from count 14; 17th s_valid not accepted.
- Wrap: push and pop continuously for 40 cycles with m_ready=1 -> output sequence equals input sequence, count steady at 1.
- Hold mode: HOLD_OBJ=1, push 5 triangles with s_last only on the 5th -> m_valid=0 until the cycle after the 5th push, then 5 pops with m_last=1 on the last.
- Deadlock release: HOLD_OBJ=1, 16 pushes with no s_last -> m_valid=1 at count 16.
- Flush and reset: count=7 with simultaneous push and flush_in -> count 0 next cycle; rst_in low mid-burst -> m_valid=0 asynchronously.
- HWM: with TRI_BUFFER_HWM_EN, fill to 9, then drain -> hwm_out=9; after flush_in -> hwm_out=0.

Source files
------------

// File: rtl/tri_buffer.sv
// tri_buffer: triangle FIFO with optional object-gated output (HOLD_OBJ).
// Define TRI_BUFFER_HWM_EN to add the hwm_out high-water-mark port.
module tri_buffer #(
  parameter int W        = 32,
  parameter int NC       = 4,
  parameter int NV       = 3,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter bit HOLD_OBJ = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NV*NC*W-1:0]      s_tri,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NV*NC*W-1:0]      m_tri,
  output logic                    m_last,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    almost_full_out
`ifdef TRI_BUFFER_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]  hwm_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = NV * NC * W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF   = (AW+1)'(AF_LEVEL);
  logic [TW:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt, r_obj, w_cnt_nx, w_obj_nx;
  logic          r_live, r_af, w_full, w_push, w_pop;
  always_comb begin
    w_full          = r_cnt == FULL;
    s_ready         = r_live && !w_full;
    m_valid         = (r_cnt != '0) && (!HOLD_OBJ || (r_obj != '0) || w_full);
    m_tri           = r_mem[r_rd][TW-1:0];
    m_last          = m_valid && r_mem[r_rd][TW];
    count_out       = r_cnt;
    almost_full_out = r_af;
    w_push          = s_valid && s_ready && !flush_in;
    w_pop           = m_valid && m_ready && !flush_in;
    w_cnt_nx        = flush_in ? '0 : r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_obj_nx        = flush_in ? '0 : r_obj + (AW+1)'(w_push && s_last) - (AW+1)'(w_pop && m_last);
  end
  // r_live keeps s_ready low until the first edge after reset release
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_live <= 1'b0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_obj  <= '0;
      r_af   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_wr   <= flush_in ? '0 : r_wr + AW'(w_push);
      r_rd   <= flush_in ? '0 : r_rd + AW'(w_pop);
      r_cnt  <= w_cnt_nx;
      r_obj  <= w_obj_nx;
      r_af   <= w_cnt_nx >= AF;
    end
  end
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr] <= {s_last, s_tri};
  end
`ifdef TRI_BUFFER_HWM_EN
  logic [AW:0] r_hwm;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_hwm <= '0;
    else r_hwm <= flush_in ? '0 : (w_cnt_nx > r_hwm ? w_cnt_nx : r_hwm);
  end
  assign hwm_out = r_hwm;
`endif
endmodule

// File: tb/tb_tri_buffer.sv
// tb_tri_buffer: drives a streaming and an object-gated tri_buffer with shared stimulus
// and checks both against queue-based reference models.
module tb_tri_buffer;
  localparam int W = 8, NC = 4, NV = 3, DEPTH = 16, TW = NV * NC * W;
  typedef struct {
    logic [TW-1:0] t;
    logic          l;
  } ent_t;
  logic          clk = 1'b0, rst_in = 1'b1, flush_in = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [TW-1:0] s_tri = '0;
  logic          sr [2], mv [2], ml [2], af [2];
  logic [TW-1:0] mt [2];
  logic [4:0]    cnt [2];
`ifdef TRI_BUFFER_HWM_EN
  logic [4:0]    hw [2];
`endif
  ent_t q [2][$];
  int   hwm [2];
  bit   live = 1'b0;
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tri_buffer #(.W(W), .NC(NC), .NV(NV), .DEPTH(DEPTH), .HOLD_OBJ(g == 1)) u_dut (
      .clk_in(clk), .rst_in(rst_in), .flush_in(flush_in),
      .s_valid(s_valid), .s_ready(sr[g]), .s_tri(s_tri), .s_last(s_last),
      .m_valid(mv[g]), .m_ready(m_ready), .m_tri(mt[g]), .m_last(ml[g]),
      .count_out(cnt[g]), .almost_full_out(af[g])
`ifdef TRI_BUFFER_HWM_EN
      , .hwm_out(hw[g])
`endif
    );
  end
  task automatic chk(input string tag, input int d, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask
  function automatic bit exp_mv(input int d);
    int n = 0;
    for (int i = 0; i < q[d].size(); i++) n += int'(q[d][i].l);
    return q[d].size() != 0 && (d == 0 || n != 0 || q[d].size() == DEPTH);
  endfunction
  task automatic step(input logic sv, input logic sl, input logic mr, input logic fl);
    logic [TW-1:0] t;
    bit push [2], pop [2], ev;
    ent_t e;
    @(negedge clk);
    t = {$urandom, $urandom, $urandom};
    s_valid = sv; s_last = sl; m_ready = mr; flush_in = fl; s_tri = t;
    #1;
    for (int d = 0; d < 2; d++) begin
      ev = exp_mv(d);
      chk("count", d, cnt[d], q[d].size());
      chk("s_ready", d, sr[d], live && q[d].size() < DEPTH);
      chk("m_valid", d, mv[d], ev);
      chk("almost_full", d, af[d], q[d].size() >= DEPTH - 2);
      if (ev) begin
        chk("m_tri", d, mt[d], q[d][0].t);
        chk("m_last", d, ml[d], q[d][0].l);
      end
`ifdef TRI_BUFFER_HWM_EN
      chk("hwm", d, hw[d], hwm[d]);
`endif
      push[d] = sv && live && q[d].size() < DEPTH;
      pop[d]  = ev && mr;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fl) begin
        q[d].delete();
        hwm[d] = 0;
      end else begin
        if (pop[d]) void'(q[d].pop_front());
        if (push[d]) begin
          e.t = t; e.l = sl;
          q[d].push_back(e);
        end
      end
      if (q[d].size() > hwm[d]) hwm[d] = q[d].size();
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_in = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_m_valid", d, mv[d], 0);
      chk("rst_m_last", d, ml[d], 0);
      chk("rst_s_ready", d, sr[d], 0);
      chk("rst_count", d, cnt[d], 0);
      chk("rst_af", d, af[d], 0);
`ifdef TRI_BUFFER_HWM_EN
      chk("rst_hwm", d, hw[d], 0);
`endif
      q[d].delete();
      hwm[d] = 0;
    end
    live = 1'b0;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("rel_s_ready", d, sr[d], 0);
    @(posedge clk);
    live = 1'b1;
  endtask
  initial begin
    do_reset();
    repeat (17) step(1, 0, 0, 0);
    repeat (17) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    repeat (40) step(1, 1'($urandom_range(0, 1)), 1, 0);
    step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, i == 4, 0, 0);
    repeat (6) step(0, 0, 1, 0);
    repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    step(0, 0, 0, 1);
    repeat (7) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    repeat (9) step(1, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    repeat (6) step(1, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    do_reset();
    repeat (30) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
